// File: rtl/doodle_motion_controller.sv
// Doodle motion controller: owns doodle X/Y and signed vertical velocity, advanced once per frame tick.
// Latency: tick in WAIT -> |vel| clocks of one-pixel vertical steps (busy high), then back to WAIT.
// Backpressure: none; ticks arriving outside WAIT are dropped. DOODLE_HWRAP_EN selects horizontal wrap (default clamp).
module doodle_motion_controller #(
   parameter int SCREEN_WIDTH  = 400,
   parameter int SCREEN_HEIGHT = 700,
   parameter int START_X       = 200,
   parameter int START_Y       = 600,
   parameter int JUMP_VELOCITY = 12,
   parameter int GRAVITY       = 1,
   parameter int MAX_FALL      = 10,
   parameter int H_SPEED       = 4
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        start,
   input  logic        tick,
   input  logic        moveLeft,
   input  logic        moveRight,
   input  logic        hasCollide,
   input  logic [31:0] collisionY,
   output logic [31:0] doodleX,
   output logic [31:0] doodleY,
   output logic        falling,
   output logic        busy,
   output logic        gameOver,
   output logic [15:0] bounceCount
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STEP, S_OVER} state_t;

   localparam logic [31:0]       X_START  = 32'(START_X);
   localparam logic [31:0]       Y_START  = 32'(START_Y);
   localparam logic [31:0]       X_STEP   = 32'(H_SPEED);
   localparam logic [31:0]       X_LIMIT  = 32'(SCREEN_WIDTH);
   localparam logic [31:0]       Y_FLOOR  = 32'(SCREEN_HEIGHT - 1);
   localparam logic signed [8:0] VEL_GRAV = 9'(GRAVITY);
   localparam logic signed [8:0] VEL_MAX  = 9'(MAX_FALL);
   localparam logic [7:0]        VEL_JUMP = 8'(-JUMP_VELOCITY);

   state_t             state_q, state_d;
   logic [31:0]        x_q, x_d;
   logic [31:0]        y_q, y_d;
   logic signed [7:0]  vel_q, vel_d;
   logic [7:0]         steps_q, steps_d;
   logic               dir_dn_q, dir_dn_d;
   logic [15:0]        bounce_q, bounce_d;

   logic signed [8:0]  vel_sum;
   logic signed [7:0]  vel_grav;
   logic [7:0]         vel_abs;
   logic [31:0]        x_left;
   logic [31:0]        x_right;
   logic               collision_y_unused;

   // The detector's Y is informational; the bounce decision relies only on hasCollide.
   assign collision_y_unused = ^collisionY;

   // Saturating gravity step, |vel|, and the two candidate horizontal positions.
   always_comb begin
      vel_sum  = $signed({vel_q[7], vel_q}) + VEL_GRAV;
      vel_grav = (vel_sum > VEL_MAX) ? VEL_MAX[7:0] : vel_sum[7:0];
      vel_abs  = vel_q[7] ? 8'(-vel_q) : vel_q;
`ifdef DOODLE_HWRAP_EN
      // Left edge is tested before subtracting so the unsigned result never wraps.
      x_left  = (x_q < X_STEP) ? (x_q + X_LIMIT - X_STEP) : (x_q - X_STEP);
      x_right = (x_q + X_STEP >= X_LIMIT) ? (x_q + X_STEP - X_LIMIT) : (x_q + X_STEP);
`else
      x_left  = (x_q < X_STEP) ? 32'd0 : (x_q - X_STEP);
      x_right = (x_q + X_STEP >= X_LIMIT) ? (X_LIMIT - 32'd1) : (x_q + X_STEP);
`endif
   end

   // Next-state: tick handling in WAIT, one-pixel sub-steps in STEP, start overrides everything.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vel_d    = vel_q;
      steps_d  = steps_q;
      dir_dn_d = dir_dn_q;
      bounce_d = bounce_q;
      case (state_q)
         S_WAIT: begin
            if (tick) begin
               if (moveLeft && !moveRight) begin
                  x_d = x_left;
               end else if (moveRight && !moveLeft) begin
                  x_d = x_right;
               end
               steps_d  = vel_abs;
               dir_dn_d = !vel_q[7];
               if (vel_q == 8'sd0) begin
                  vel_d = vel_grav;
               end else begin
                  state_d = S_STEP;
               end
            end
         end
         S_STEP: begin
            if (dir_dn_q && hasCollide) begin
               // Bounce happens on the pixel where contact is seen; Y does not move this cycle.
               vel_d   = VEL_JUMP;
               steps_d = 8'd0;
               state_d = S_WAIT;
               if (bounce_q != 16'hFFFF) begin
                  bounce_d = bounce_q + 16'd1;
               end
            end else if (dir_dn_q && (y_q == Y_FLOOR)) begin
               state_d = S_OVER;
            end else if (!dir_dn_q && (y_q == 32'd0)) begin
               vel_d   = 8'sd0;
               steps_d = 8'd0;
               state_d = S_WAIT;
            end else begin
               y_d     = dir_dn_q ? (y_q + 32'd1) : (y_q - 32'd1);
               steps_d = steps_q - 8'd1;
               if (steps_q == 8'd1) begin
                  vel_d   = vel_grav;
                  state_d = S_WAIT;
               end
            end
         end
         default: ;
      endcase
      if (start) begin
         state_d  = S_WAIT;
         x_d      = X_START;
         y_d      = Y_START;
         vel_d    = 8'sd0;
         steps_d  = 8'd0;
         dir_dn_d = 1'b0;
         bounce_d = 16'd0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= S_IDLE;
         x_q      <= X_START;
         y_q      <= Y_START;
         vel_q    <= 8'sd0;
         steps_q  <= 8'd0;
         dir_dn_q <= 1'b0;
         bounce_q <= 16'd0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vel_q    <= vel_d;
         steps_q  <= steps_d;
         dir_dn_q <= dir_dn_d;
         bounce_q <= bounce_d;
      end
   end

   assign doodleX     = x_q;
   assign doodleY     = y_q;
   assign falling     = (vel_q > 8'sd0);
   assign busy        = (state_q == S_STEP);
   assign gameOver    = (state_q == S_OVER);
   assign bounceCount = bounce_q;

endmodule

// File: tb/tb_doodle_motion_controller.sv
// Directed bench for doodle_motion_controller: free fall to game over, bounce climb to the ceiling,
// async reset mid-step, and horizontal edge handling (clamp or wrap depending on DOODLE_HWRAP_EN).
// hasCollide is produced here as a stand-in for the collision detector.
module tb_doodle_motion_controller;

   logic        clk = 1'b0;
   logic        resetN;
   logic        start;
   logic        tick;
   logic        moveLeft;
   logic        moveRight;
   logic        hasCollide;
   logic [31:0] collisionY;
   logic [31:0] doodleX;
   logic [31:0] doodleY;
   logic        falling;
   logic        busy;
   logic        gameOver;
   logic [15:0] bounceCount;

   logic        coll_all;
   logic        coll_en;
   logic [31:0] coll_y;

   int n_chk  = 0;
   int n_pass = 0;

   // Free fall from y=600: Y and busy length after each tick (velocity 0,1,...,10 capped).
   int ff_y[16]  = '{600, 601, 603, 606, 610, 615, 621, 628, 636, 645, 655, 665, 675, 685, 695, 699};
   int ff_nb[16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10, 10, 10, 10, 5};
   // Bounce points while climbing: each bounce rises 12+11+...+1 = 78 px.
   int bounce_y[8] = '{600, 522, 444, 366, 288, 210, 132, 54};
   int rise_off[12] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78};
   // Final rise from 54: 42,31,21,12,4, then velocity -7 hits the ceiling after 4 px.
   int ceil_y[6]  = '{42, 31, 21, 12, 4, 0};
   int ceil_nb[6] = '{12, 11, 10, 9, 8, 5};
   // Horizontal segments: tick count, direction (1 left, 2 right, 3 both), resulting X.
   int hx_n[8]   = '{50, 1, 1, 99, 1, 1, 99, 1};
   int hx_dir[8] = '{1, 1, 2, 2, 2, 3, 1, 1};
`ifdef DOODLE_HWRAP_EN
   int hx_exp[8] = '{0, 396, 0, 396, 0, 0, 4, 0};
`else
   int hx_exp[8] = '{0, 0, 4, 399, 399, 399, 3, 0};
`endif

   assign hasCollide = coll_all | (coll_en && (doodleY == coll_y));
   assign collisionY = doodleY;

   always #5 clk = ~clk;

   doodle_motion_controller dut (
      .clk         (clk),
      .resetN      (resetN),
      .start       (start),
      .tick        (tick),
      .moveLeft    (moveLeft),
      .moveRight   (moveRight),
      .hasCollide  (hasCollide),
      .collisionY  (collisionY),
      .doodleX     (doodleX),
      .doodleY     (doodleY),
      .falling     (falling),
      .busy        (busy),
      .gameOver    (gameOver),
      .bounceCount (bounceCount)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   // One tick pulse followed by a fixed 20-cycle window; counts cycles with busy high.
   // extra_at >= 0 re-pulses tick at that window cycle (should be ignored while stepping).
   task automatic do_tick(input int extra_at, output int nbusy);
      nbusy = 0;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) nbusy++;
         tick = (i == extra_at);
         @(negedge clk);
      end
      tick = 1'b0;
   endtask

   initial begin
      int nb;
      resetN = 1'b0; start = 1'b0; tick = 1'b0; moveLeft = 1'b0; moveRight = 1'b0;
      coll_all = 1'b0; coll_en = 1'b0; coll_y = 32'd0;
      #12;
      chk("rst_x", doodleX, 200);
      chk("rst_y", doodleY, 600);
      chk("rst_falling", falling, 0);
      chk("rst_busy", busy, 0);
      chk("rst_over", gameOver, 0);
      chk("rst_bounces", bounceCount, 0);
      @(negedge clk); resetN = 1'b1;

      // IDLE ignores tick.
      do_tick(-1, nb);
      chk("idle_tick_busy", nb, 0);
      chk("idle_tick_y", doodleY, 600);
      chk("idle_tick_falling", falling, 0);

      // Free fall to the floor.
      pulse_start();
      for (int k = 0; k < 16; k++) begin
         do_tick(-1, nb);
         chk($sformatf("fall_y[%0d]", k), doodleY, ff_y[k]);
         chk($sformatf("fall_busy[%0d]", k), nb, ff_nb[k]);
      end
      chk("fall_over", gameOver, 1);
      do_tick(-1, nb);
      chk("over_tick_busy", nb, 0);
      chk("over_tick_y", doodleY, 699);

      // Restart from OVER.
      pulse_start();
      chk("restart_x", doodleX, 200);
      chk("restart_y", doodleY, 600);
      chk("restart_over", gameOver, 0);
      chk("restart_bounces", bounceCount, 0);
      chk("restart_falling", falling, 0);

      // Climb by bouncing at the bottom of every arc, then hit the ceiling.
      do_tick(-1, nb);
      chk("climb_vel1_falling", falling, 1);
      coll_en = 1'b1;
      for (int b = 0; b < 8; b++) begin
         coll_y = bounce_y[b];
         do_tick(-1, nb);
         chk($sformatf("bounce_y[%0d]", b), doodleY, bounce_y[b]);
         chk($sformatf("bounce_cnt[%0d]", b), bounceCount, b + 1);
         chk($sformatf("bounce_busy[%0d]", b), nb, 1);
         chk($sformatf("bounce_falling[%0d]", b), falling, 0);
         if (b < 7) begin
            if (b == 0) coll_y = 32'd595;
            for (int r = 0; r < 12; r++) begin
               do_tick((b == 0 && r == 0) ? 3 : -1, nb);
               if (b == 0) begin
                  chk($sformatf("rise_y[%0d]", r), doodleY, 600 - rise_off[r]);
                  chk($sformatf("rise_busy[%0d]", r), nb, 12 - r);
               end
            end
            if (b == 0) chk("rise_through_bounces", bounceCount, 1);
            do_tick(-1, nb);
            chk($sformatf("apex_y[%0d]", b), doodleY, bounce_y[b + 1]);
            chk($sformatf("apex_falling[%0d]", b), falling, 1);
         end
      end
      for (int c = 0; c < 6; c++) begin
         do_tick(-1, nb);
         chk($sformatf("ceil_y[%0d]", c), doodleY, ceil_y[c]);
         chk($sformatf("ceil_busy[%0d]", c), nb, ceil_nb[c]);
      end
      chk("ceil_falling", falling, 0);
      chk("ceil_bounces", bounceCount, 8);
      do_tick(-1, nb);
      chk("ceil_vel0_busy", nb, 0);
      chk("ceil_vel0_y", doodleY, 0);
      chk("ceil_vel0_falling", falling, 1);

      // Async reset in the middle of a two-pixel step.
      coll_en = 1'b0;
      do_tick(-1, nb);
      chk("pre_rst_y", doodleY, 1);
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("pre_rst_busy", busy, 1);
      #2 resetN = 1'b0;
      #1;
      chk("mid_rst_x", doodleX, 200);
      chk("mid_rst_y", doodleY, 600);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_falling", falling, 0);
      chk("mid_rst_over", gameOver, 0);
      chk("mid_rst_bounces", bounceCount, 0);
      @(negedge clk); resetN = 1'b1;

      // Horizontal movement; constant contact keeps the doodle bouncing near the bottom.
      pulse_start();
      coll_all = 1'b1;
      for (int s = 0; s < 8; s++) begin
         moveLeft  = (hx_dir[s] == 1) || (hx_dir[s] == 3);
         moveRight = (hx_dir[s] == 2) || (hx_dir[s] == 3);
         for (int t = 0; t < hx_n[s]; t++) do_tick(-1, nb);
         chk($sformatf("hx_seg[%0d]", s), doodleX, hx_exp[s]);
      end
      moveLeft = 1'b0; moveRight = 1'b0; coll_all = 1'b0;
      chk("hx_not_over", gameOver, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/doodle_motion_controller.md
Name: doodle_motion_controller

Overview:
- Downstream consumer of the collision detector: owns the doodle's position and vertical velocity and advances them once per frame tick.
- Vertical motion is applied one pixel per clock (sub-stepping), so the detector's exact-equality Y test (doodleY == blockY) can never be skipped.
- Outputs doodleX/doodleY feed back into the detector; its hasCollide/collisionY return combinationally in the same cycle.

Parameters:
- SCREEN_WIDTH, 400, horizontal extent in pixels
- SCREEN_HEIGHT, 700, vertical extent; y=0 is top, y grows downward
- START_X, 200, doodleX loaded on start
- START_Y, 600, doodleY loaded on start
- JUMP_VELOCITY, 12, upward speed (px/tick) applied on bounce
- GRAVITY, 1, velocity increment per tick
- MAX_FALL, 10, maximum downward velocity (px/tick)
- H_SPEED, 4, horizontal step per tick

Ports:
- clk  input  1  system clock
- resetN  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a game
- tick  input  1  one-cycle frame pulse
- moveLeft  input  1  player left button, level
- moveRight  input  1  player right button, level
- hasCollide  input  1  from detector, valid for current doodleX/doodleY
- collisionY  input  32  from detector, informational only
- doodleX  output  32  doodle horizontal position
- doodleY  output  32  doodle vertical position
- falling  output  1  1 while velocity > 0
- busy  output  1  1 in STEP state
- gameOver  output  1  1 in OVER state
- bounceCount  output  16  bounces since start, saturating at 16'hFFFF

Behaviour:
- Reset (async, resetN=0): state=IDLE; doodleX=START_X; doodleY=START_Y; vel=0 (signed 8-bit, negative=up); stepsLeft=0; bounceCount=0; all flags 0.
- States: IDLE, WAIT, STEP, OVER.
- IDLE: wait for start.
  - start -> load START_X/START_Y, vel=0, bounceCount=0 -> WAIT.
- WAIT, on tick:
  - Horizontal: moveLeft only -> x-H_SPEED; moveRight only -> x+H_SPEED; both or neither -> unchanged. Edge handling per Optional Feature.
  - stepsLeft=|vel|, dir=sign(vel).
  - If vel==0: vel=min(vel+GRAVITY, MAX_FALL), stay WAIT. Else -> STEP.
- STEP: one clock per pixel.
  - dir down and hasCollide=1 at current doodleY: bounce. vel=-JUMP_VELOCITY; stepsLeft=0; bounceCount++ (saturating); -> WAIT. doodleY is not moved that cycle.
  - dir down, no collision, doodleY==SCREEN_HEIGHT-1: -> OVER, position frozen.
  - dir down, otherwise: doodleY+1.
  - dir up: hasCollide is ignored (the doodle passes through blocks). At doodleY==0: clamp, vel=0, stepsLeft=0, -> WAIT. Otherwise doodleY-1.
  - When stepsLeft reaches 0 without a bounce or ceiling hit: vel=min(vel+GRAVITY, MAX_FALL) -> WAIT.
- Latency:
  - tick at cycle t -> first pixel move at the edge after t+1; with n=|vel|, busy is high for n cycles and WAIT is re-entered at t+n+1.
  - Caller's tick period must exceed MAX_FALL+2 and JUMP_VELOCITY+2 clocks.
- tick while in STEP, IDLE or OVER: ignored, not queued.
- start in WAIT/STEP/OVER: restarts (same as from IDLE), aborts any pending steps.
- Reset mid-STEP: immediate return to reset values.
- falling is combinational from vel (vel > 0). busy = (state==STEP). gameOver = (state==OVER).
- Arithmetic:
  - Velocity is signed 8-bit with saturation against MAX_FALL.
  - X/Y are 32-bit unsigned. Left underflow is detected by x < H_SPEED, never by a wrapped result.

Optional Feature:
- Macro: DOODLE_HWRAP_EN.
- Defined: horizontal wrap-around.
  - Left with x < H_SPEED -> x + SCREEN_WIDTH - H_SPEED.
  - Right with x + H_SPEED >= SCREEN_WIDTH -> x + H_SPEED - SCREEN_WIDTH.
- Undefined: clamp. Left below 0 -> 0; right beyond the edge -> SCREEN_WIDTH-1.

Test Plan:
- Reset then start; no hasCollide; ticks every 20 clocks -> vel 0,1,2,...,10 (capped); doodleY 600,600,601,603,606,...; once doodleY hits 699: gameOver=1 and doodleY holds at 699.
- Falling with vel=3 from y=100; hasCollide forced high when doodleY==102 -> bounce at 102; vel=-12; bounceCount=1; busy drops the cycle after the bounce; next tick moves doodleY to 90 over 12 clocks.
- Rising through a block: hasCollide=1 while vel<0 at doodleY=95 -> no bounce, doodleY continues decreasing, bounceCount unchanged.
- Ceiling: bounce at y=5 -> next tick rises 5 px to 0, clamps; vel=0; WAIT after 6 clocks.
- Horizontal at x=2, moveLeft, one tick -> with DOODLE_HWRAP_EN: 398; without: 0. At x=398, moveRight -> with: 2; without: 399. Both buttons -> x unchanged.
- tick pulsed during STEP -> ignored (step count unchanged). resetN low mid-STEP -> all outputs return to reset values asynchronously. start in OVER -> doodle at (200,600), gameOver=0, bounceCount=0.
